// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the memory-stage access unit.
package riscv_mem_pkg;

  // funct3 encodings for load/store size; the remaining codes are treated as word
  typedef enum logic [2:0] {
    MEM_LB  = 3'b000,
    MEM_LH  = 3'b001,
    MEM_LW  = 3'b010,
    MEM_LBU = 3'b100,
    MEM_LHU = 3'b101
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RESP,
    DONE
  } mem_state_e;

  localparam logic [1:0]  RESULTSRC_LOAD = 2'b01;
  localparam logic [31:0] BUS_ERR_DATA   = 32'hDEAD_BEEF;

  // Byte enables for a store of the given size at byte offset off
  function automatic logic [3:0] store_strb(input logic [2:0] size, input logic [1:0] off);
    logic [3:0] strb;
    case (size[1:0])
      2'b00:   strb = 4'b0001 << off;
      2'b01:   strb = 4'b0011 << {off[1], 1'b0};
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: selects the addressed byte/half of the raw word and extends it.
module mem_load_align
  import riscv_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  size,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select and sign/zero extension
  always_comb begin
    byte_sel = rdata[{off, 3'b000} +: 8];
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    case (mem_size_e'(size))
      MEM_LB:  result = {{24{byte_sel[7]}}, byte_sel};
      MEM_LH:  result = {{16{half_sel[15]}}, half_sel};
      MEM_LBU: result = {24'h0, byte_sel};
      MEM_LHU: result = {16'h0, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_access.sv
// Memory-stage access unit: issues a valid/ready data-memory request for the instruction
// held in EX/MEM, aligns store lanes, returns extended load data and stalls upstream
// until the access completes. Define MEM_MISALIGN_TRAP_EN to reject misaligned half/word
// accesses without issuing a request (adds the MisalignM output).
module mem_stage_access
  import riscv_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  input  logic                  MemWriteM,
  input  logic [1:0]            ResultSrcM,
  input  logic [2:0]            MemSizeM,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] ReadDataM,
  output logic                  StallM,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic                  MisalignM,
`endif
  output logic                  BusErrM
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  mem_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  logic [31:0]     addr_q, wdata_q, rdata_q;
  logic [3:0]      wstrb_q;
  logic            we_q, bus_err_q;
  logic [1:0]      off_q;
  logic [2:0]      size_q;

  logic        access;
  logic        timeout;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_wstrb;
  logic [31:0] load_result;

`ifdef MEM_MISALIGN_TRAP_EN
  logic misaligned;
  logic misalign_q;

  // Half at odd address, or any word access not on a 4-byte boundary
  always_comb begin
    misaligned = (MemSizeM[1:0] == 2'b01 && ALUResultM[0]) ||
                 (MemSizeM[1] && ALUResultM[1:0] != 2'b00);
  end

  assign MisalignM = misalign_q;
`endif

  // Access decode, store lane replication and timeout detection
  always_comb begin
    access     = MemWriteM | (ResultSrcM == RESULTSRC_LOAD);
    timeout    = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
    lane_wstrb = store_strb(MemSizeM, ALUResultM[1:0]);
    case (MemSizeM[1:0])
      2'b00:   lane_wdata = {4{WriteDataM[7:0]}};
      2'b01:   lane_wdata = {2{WriteDataM[15:0]}};
      default: lane_wdata = WriteDataM;
    endcase
  end

  mem_load_align u_load_align (
    .rdata  (mem_rdata),
    .off    (off_q),
    .size   (size_q),
    .result (load_result)
  );

  // Access FSM with timeout counter and registered request/result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      we_q      <= 1'b0;
      off_q     <= '0;
      size_q    <= '0;
      rdata_q   <= '0;
      bus_err_q <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      bus_err_q <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (access) begin
            // Capture the request so it stays stable for the whole handshake
            addr_q  <= {ALUResultM[31:2], 2'b00};
            wdata_q <= lane_wdata;
            wstrb_q <= lane_wstrb;
            we_q    <= MemWriteM;
            off_q   <= ALUResultM[1:0];
            size_q  <= MemSizeM;
`ifdef MEM_MISALIGN_TRAP_EN
            if (misaligned) begin
              misalign_q <= 1'b1;
              state_q    <= DONE;
            end else begin
              state_q <= REQ;
            end
`else
            state_q <= REQ;
`endif
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            cnt_q   <= '0;
            state_q <= we_q ? DONE : WAIT_RESP;
          end else if (timeout) begin
            cnt_q     <= '0;
            bus_err_q <= 1'b1;
            if (!we_q) rdata_q <= BUS_ERR_DATA;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT_RESP: begin
          if (mem_resp_valid) begin
            cnt_q   <= '0;
            rdata_q <= load_result;
            state_q <= DONE;
          end else if (timeout) begin
            cnt_q     <= '0;
            bus_err_q <= 1'b1;
            rdata_q   <= BUS_ERR_DATA;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_req_valid = (state_q == REQ);
  assign mem_addr      = addr_q;
  assign mem_we        = we_q;
  assign mem_wdata     = wdata_q;
  assign mem_wstrb     = wstrb_q;
  assign ReadDataM     = rdata_q;
  assign BusErrM       = bus_err_q;
  // Gated by rst_n so upstream is never frozen while the unit is held in reset
  assign StallM        = rst_n & access & (state_q != DONE);

endmodule
